// File: rtl/qrd_skew_feeder_pkg.sv
// Shared types and constants for the QRD row-input skew feeder.
package qrd_pkg;

  localparam int N     = 4;
  localparam int W     = 14;
  localparam int FRAC  = 10;
  localparam int DEPTH = N * N;

  localparam logic signed [W-1:0] ONE_FX = W'(1 << FRAC);

  typedef struct packed {
    logic signed [W-1:0] r;
    logic signed [W-1:0] i;
  } cplx_t;

  typedef enum logic {
    LOAD,
    STREAM
  } state_t;

endpackage

// File: rtl/qrd_skew_feeder_mat_buf.sv
// 16-entry complex register file: one raster-order write port and N
// combinational read ports, one per systolic lane.
module qrd_mat_buf
  import qrd_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [3:0]           i_waddr,
  input  cplx_t                i_wdata,
  input  logic [N-1:0][3:0]    i_raddr,
  output cplx_t [N-1:0]        o_rdata
);

  cplx_t r_mem [DEPTH];

  // Raster write of one H element
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Per-lane combinational read
  always_comb begin
    o_rdata = '0;
    for (int unsigned k = 0; k < N; k++) o_rdata[k] = r_mem[i_raddr[k]];
  end

endmodule

// File: rtl/qrd_skew_feeder.sv
// Transmit side of the QRD core row-input interface: buffers a 4x4 complex
// H matrix and streams the skewed [H | I] beats onto the row_in_* lanes.
// Optional macro QRD_FEEDER_DBUF_EN selects ping-pong buffering.
module qrd_skew_feeder
  import qrd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_data_r,
  input  logic signed [W-1:0] s_data_i,
  input  logic                in_ready,
  output logic signed [W-1:0] row_in_1_r,
  output logic signed [W-1:0] row_in_1_i,
  output logic signed [W-1:0] row_in_2_r,
  output logic signed [W-1:0] row_in_2_i,
  output logic signed [W-1:0] row_in_3_r,
  output logic signed [W-1:0] row_in_3_i,
  output logic signed [W-1:0] row_in_4_r,
  output logic signed [W-1:0] row_in_4_i,
  output logic                row_in_1_f,
  output logic                row_in_2_f,
  output logic                row_in_3_f,
  output logic                busy,
  output logic                frame_done
);

  state_t            r_state;
  logic [3:0]        r_ptr;
  logic [3:0]        r_beat;
  cplx_t [N-1:0]     r_lane;
  logic [N-2:0]      r_flag;
  logic              r_busy;
  logic              r_done;

  logic              w_wr;
  logic              w_last_wr;
  logic              w_acc;
  logic              w_acc_last;
  logic              w_swap_go;
  logic              w_load;
  logic [3:0]        w_nl;
  cplx_t             w_wdata;
  cplx_t [N-1:0]     w_rdata;
  cplx_t [N-1:0]     w_lane;
  logic [N-2:0]      w_flag;
  logic [N-1:0][3:0] w_raddr;

  assign w_wdata    = {s_data_r, s_data_i};
  assign w_wr       = s_valid & s_ready;
  assign w_last_wr  = w_wr & (r_ptr == 4'd15);
  assign w_acc      = (r_state == STREAM) & in_ready;
  assign w_acc_last = w_acc & (r_beat == 4'd15);

`ifdef QRD_FEEDER_DBUF_EN
  logic          r_front;
  logic          r_back_full;
  logic          w_wsel;
  logic          w_rsel;
  cplx_t [N-1:0] w_rdata0;
  cplx_t [N-1:0] w_rdata1;

  // LOAD fills the front bank; STREAM fills the back bank.
  assign w_wsel    = (r_state == LOAD) ? r_front : ~r_front;
  assign s_ready   = (r_state == LOAD) | ~r_back_full;
  // A back-bank fill completing on the beat-15 edge still counts as full.
  assign w_swap_go = w_acc_last & (r_back_full | w_last_wr);
  assign w_rsel    = w_swap_go ? ~r_front : r_front;
  assign w_rdata   = w_rsel ? w_rdata1 : w_rdata0;

  qrd_mat_buf u_buf0 (
    .clk     (clk),
    .i_we    (w_wr & ~w_wsel),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata0)
  );

  qrd_mat_buf u_buf1 (
    .clk     (clk),
    .i_we    (w_wr & w_wsel),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata1)
  );

  // Bank ownership: banks always swap at the end of a frame; a partially
  // filled back bank becomes the front and LOAD resumes at the same pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front     <= 1'b0;
      r_back_full <= 1'b0;
    end else begin
      if (r_state == STREAM && w_last_wr) r_back_full <= 1'b1;
      if (w_acc_last) begin
        r_front     <= ~r_front;
        r_back_full <= 1'b0;
      end
    end
  end
`else
  assign w_swap_go = 1'b0;
  assign s_ready   = (r_state == LOAD);

  qrd_mat_buf u_buf (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );
`endif

  // Select which beat (if any) the output registers load this cycle
  always_comb begin
    w_load = 1'b0;
    w_nl   = '0;
    if (r_state == LOAD && w_last_wr) begin
      w_load = 1'b1;
    end else if (w_acc && !w_acc_last) begin
      w_load = 1'b1;
      w_nl   = r_beat + 4'd1;
    end else if (w_swap_go) begin
      w_load = 1'b1;
    end
  end

  // Lane column mux for beat w_nl: buffer, identity or zero.
  // Beat 0 only reads entry 0, so the entry written on the same edge is never needed.
  always_comb begin
    logic [4:0] w_col;
    w_lane  = '0;
    w_flag  = '0;
    w_raddr = '0;
    w_col   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_col      = 5'(w_nl) - 5'(k);
      w_raddr[k] = {2'(k), w_col[1:0]};
      if (w_nl >= 4'(k) && w_col < 5'(2 * N)) begin
        if (w_col < 5'(N))                  w_lane[k]   = w_rdata[k];
        else if (w_col - 5'(N) == 5'(k))    w_lane[k].r = ONE_FX;
      end
    end
    for (int unsigned k = 0; k < N - 1; k++) w_flag[k] = (5'(w_nl) == 5'(2 * k));
  end

  // FSM, write pointer, beat counter and registered lane outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_ptr   <= '0;
      r_beat  <= '0;
      r_lane  <= '0;
      r_flag  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr) r_ptr <= r_ptr + 4'd1;
      if (w_load) begin
        r_lane <= w_lane;
        r_flag <= w_flag;
      end
      unique case (r_state)
        LOAD: begin
          if (w_last_wr) begin
            r_state <= STREAM;
            r_beat  <= '0;
            r_busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (w_acc) begin
            if (!w_acc_last) begin
              r_beat <= r_beat + 4'd1;
            end else begin
              r_done <= 1'b1;
              r_beat <= '0;
              if (!w_swap_go) begin
                r_state <= LOAD;
                r_busy  <= 1'b0;
                r_lane  <= '0;
                r_flag  <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign row_in_1_r = r_lane[0].r;
  assign row_in_1_i = r_lane[0].i;
  assign row_in_2_r = r_lane[1].r;
  assign row_in_2_i = r_lane[1].i;
  assign row_in_3_r = r_lane[2].r;
  assign row_in_3_i = r_lane[2].i;
  assign row_in_4_r = r_lane[3].r;
  assign row_in_4_i = r_lane[3].i;
  assign row_in_1_f = r_flag[0];
  assign row_in_2_f = r_flag[1];
  assign row_in_3_f = r_flag[2];
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_qrd_skew_feeder.sv
// Bench for qrd_skew_feeder: frame-level reference model checked every
// cycle, plus hand-computed literal expectations for selected beats.
module tb_qrd_skew_feeder;

`ifdef QRD_FEEDER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic signed [13:0] s_data_r = '0;
  logic signed [13:0] s_data_i = '0;
  logic in_ready = 1'b0;
  logic signed [13:0] r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i;
  logic f1, f2, f3, busy, frame_done;

  qrd_skew_feeder dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_r(s_data_r), .s_data_i(s_data_i), .in_ready(in_ready),
    .row_in_1_r(r1r), .row_in_1_i(r1i), .row_in_2_r(r2r), .row_in_2_i(r2i),
    .row_in_3_r(r3r), .row_in_3_i(r3i), .row_in_4_r(r4r), .row_in_4_i(r4i),
    .row_in_1_f(f1), .row_in_2_f(f2), .row_in_3_f(f3),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int m_fr[16], m_fi[16], m_br[16], m_bi[16];
  bit m_stream = 0;
  int m_wcnt = 0, m_bcnt = 0, m_beat = 0;
  bit m_done = 0;

  function automatic bit m_sready();
    return !m_stream || (DBUF && m_bcnt < 16);
  endfunction

  // Lane k at beat l shows column l-k of [H | I] while inside its 2N window.
  function automatic void exp_lane(input int l, input int k, output int er, output int ei);
    int c = l - k;
    er = 0; ei = 0;
    if (c >= 0 && c < 8) begin
      if (c < 4) begin
        er = m_fr[k*4 + c];
        ei = m_fi[k*4 + c];
      end else if (c - 4 == k) begin
        er = 1024;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stream = 0; m_wcnt = 0; m_bcnt = 0; m_beat = 0; m_done = 0;
    end else begin
      bit wr, acc;
      wr  = s_valid && m_sready();
      acc = m_stream && in_ready;
      m_done = acc && (m_beat == 15);
      if (!m_stream) begin
        if (wr) begin
          m_fr[m_wcnt] = int'(s_data_r);
          m_fi[m_wcnt] = int'(s_data_i);
          m_wcnt++;
          if (m_wcnt == 16) begin
            m_stream = 1; m_beat = 0; m_wcnt = 0;
          end
        end
      end else begin
        if (wr) begin
          m_br[m_bcnt] = int'(s_data_r);
          m_bi[m_bcnt] = int'(s_data_i);
          m_bcnt++;
        end
        if (acc) begin
          if (m_beat < 15) m_beat++;
          else begin
            m_beat = 0;
            if (DBUF) begin
              m_fr = m_br; m_fi = m_bi;
              if (m_bcnt == 16) m_bcnt = 0;
              else begin
                m_stream = 0; m_wcnt = m_bcnt; m_bcnt = 0;
              end
            end else begin
              m_stream = 0; m_wcnt = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  logic signed [13:0] o_r[4], o_i[4];
  assign o_r[0] = r1r; assign o_i[0] = r1i;
  assign o_r[1] = r2r; assign o_i[1] = r2i;
  assign o_r[2] = r3r; assign o_i[2] = r3i;
  assign o_r[3] = r4r; assign o_i[3] = r4i;

  always @(negedge clk) begin
    if (rst_n) begin
      int er, ei;
      for (int k = 0; k < 4; k++) begin
        if (m_stream) exp_lane(m_beat, k, er, ei);
        else begin er = 0; ei = 0; end
        chk($sformatf("lane%0d_r", k + 1), int'(o_r[k]), er);
        chk($sformatf("lane%0d_i", k + 1), int'(o_i[k]), ei);
      end
      chk("flag1", int'(f1), int'(m_stream && m_beat == 0));
      chk("flag2", int'(f2), int'(m_stream && m_beat == 2));
      chk("flag3", int'(f3), int'(m_stream && m_beat == 4));
      chk("busy", int'(busy), int'(m_stream));
      chk("frame_done", int'(frame_done), int'(m_done));
      chk("s_ready", int'(s_ready), int'(m_sready()));
    end
  end

  // ---------------- stimulus ----------------
  int cap_r[4][41], cap_i[4][41], cap_rdy[41];

  task automatic load_matrix(input int base, input bit gaps);
    int idx = 0;
    int cyc = 0;
    while (idx < 16 && cyc < 200) begin
      int v;
      v = base + 16 * (idx / 4) + (idx % 4) + 1;
      s_valid  = gaps ? (cyc % 2 == 0) : 1'b1;
      s_data_r = 14'(v);
      s_data_i = 14'(-v);
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #2;
      cyc++;
    end
    s_valid = 1'b0;
    if (idx < 16) chk("load_timeout", idx, 16);
  endtask

  task automatic run_stream(input int stall_at, input int stall_len, output int done_t);
    done_t = -1;
    for (int t = 0; t < 41 && done_t < 0; t++) begin
      in_ready = !(t >= stall_at && t < stall_at + stall_len);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        cap_r[k][t] = int'(o_r[k]);
        cap_i[k][t] = int'(o_i[k]);
      end
      cap_rdy[t] = int'(s_ready);
      if (frame_done) done_t = t;
      @(posedge clk); #2;
    end
    in_ready = 1'b1;
    if (done_t < 0) chk("stream_timeout", done_t, 0);
  endtask

  initial begin
    int dt;
    @(posedge clk); #2;
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lane1_r", int'(r1r), 0);
    chk("rst_flag1", int'(f1), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // T1: basic stream
    load_matrix(0, 0);
    run_stream(99, 0, dt);
    chk("t1_b3_l1", cap_r[0][3], 4);
    chk("t1_b3_l1i", cap_i[0][3], -4);
    chk("t1_b3_l2", cap_r[1][3], 19);
    chk("t1_b3_l3", cap_r[2][3], 34);
    chk("t1_b3_l4i", cap_i[3][3], -49);
    chk("t1_b4_l1", cap_r[0][4], 1024);
    chk("t1_b6_l2", cap_r[1][6], 1024);
    chk("t1_b6_l4", cap_r[3][6], 52);
    chk("t1_b8_l1", cap_r[0][8], 0);
    chk("t1_b8_l4", cap_r[3][8], 0);
    chk("t1_done_t", dt, 16);

    // T2: 3-cycle stall at beat 5
    load_matrix(0, 0);
    run_stream(5, 3, dt);
    chk("t2_hold_l3", cap_r[2][7], 36);
    chk("t2_hold_l4i", cap_i[3][7], -51);
    chk("t2_done_t", dt, 19);

    // T5: source gaps
    load_matrix(0, 1);
    run_stream(99, 0, dt);
    chk("t5_b3_l2", cap_r[1][3], 19);
    chk("t5_b3_l4", cap_r[3][3], 49);

    // T3 / T6: source pushes the next matrix while the first streams
    load_matrix(0, 0);
    fork
      run_stream(99, 0, dt);
      load_matrix(100, 0);
    join
    chk("t3_done_t", dt, 16);
    chk("t3_s_ready", cap_rdy[5], DBUF ? 1 : 0);
    run_stream(99, 0, dt);
    chk("t3_second_done_t", dt, DBUF ? 15 : 16);
    chk("t3_second_l1", cap_r[0][3], DBUF ? 1024 : 104);

    // T4: reset at beat 7, then a fresh matrix
    load_matrix(0, 0);
    in_ready = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    chk("t4_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_busy", int'(busy), 0);
    chk("t4_s_ready", int'(s_ready), 1);
    chk("t4_lane1", int'(r1r), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    load_matrix(200, 0);
    run_stream(99, 0, dt);
    chk("t4_b0_l1", cap_r[0][0], 201);
    chk("t4_b3_l1", cap_r[0][3], 204);
    chk("t4_done_t", dt, 16);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
